// File: rtl/sram_port_arbiter.sv
// Single-port SRAM arbiter between the AXI slave read and write engines: locked bursts,
// round-robin at burst boundaries. Define SRAM_ARB_WRITE_PRIORITY_EN to let write win every tie.
module sram_port_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_last,
  output logic              rd_gnt,
  output logic              rd_rvalid,
  output logic [DATA_W-1:0] rd_rdata,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [STRB_W-1:0] wr_strb,
  input  logic              wr_last,
  output logic              wr_gnt,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_di,
  output logic [STRB_W-1:0] sram_web,
  output logic              sram_cs,
  output logic              sram_oe,
  input  logic [DATA_W-1:0] sram_do
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_LOCK = 2'd1,
    WR_LOCK = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              rd_gnt_s, wr_gnt_s;
  logic              rd_acc_s, wr_acc_s;
  logic              tie_to_rd_s;
  logic              rd_rvalid_q;
  logic [ADDR_W-1:0] sram_a_q, sram_a_d;
  logic [DATA_W-1:0] sram_di_q, sram_di_d;

`ifdef SRAM_ARB_WRITE_PRIORITY_EN
  assign tie_to_rd_s = 1'b0;
`else
  // prio_last_q = 1 means the last burst started was a write.
  logic prio_last_q, prio_last_d;

  assign tie_to_rd_s = prio_last_q;

  // Remember which side started the most recent burst.
  always_comb begin
    prio_last_d = prio_last_q;
    if ((state_q == IDLE) && rd_acc_s) begin
      prio_last_d = 1'b0;
    end else if ((state_q == IDLE) && wr_acc_s) begin
      prio_last_d = 1'b1;
    end else begin
      prio_last_d = prio_last_q;
    end
  end

  // Round-robin pointer register; after reset the first tie goes to read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_last_q <= 1'b1;
    end else begin
      prio_last_q <= prio_last_d;
    end
  end
`endif

  assign rd_acc_s = rd_gnt_s & rd_req;
  assign wr_acc_s = wr_gnt_s & wr_req;

  // Grant selection and burst-lock next state; reset forces grants low in the same cycle.
  always_comb begin
    rd_gnt_s = 1'b0;
    wr_gnt_s = 1'b0;
    state_d  = state_q;
    if (rst) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (rd_req && wr_req) begin
            rd_gnt_s = tie_to_rd_s;
            wr_gnt_s = ~tie_to_rd_s;
          end else begin
            rd_gnt_s = rd_req;
            wr_gnt_s = wr_req;
          end
        end
        RD_LOCK: rd_gnt_s = rd_req;
        WR_LOCK: wr_gnt_s = wr_req;
        default: state_d = IDLE;
      endcase

      case (state_q)
        IDLE: begin
          if (rd_gnt_s && rd_req && !rd_last) begin
            state_d = RD_LOCK;
          end else if (wr_gnt_s && wr_req && !wr_last) begin
            state_d = WR_LOCK;
          end else begin
            state_d = IDLE;
          end
        end
        RD_LOCK: begin
          if (rd_gnt_s && rd_req && rd_last) begin
            state_d = IDLE;
          end else begin
            state_d = RD_LOCK;
          end
        end
        WR_LOCK: begin
          if (wr_gnt_s && wr_req && wr_last) begin
            state_d = IDLE;
          end else begin
            state_d = WR_LOCK;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // SRAM pin drive; address and write data hold their last driven value when idle.
  always_comb begin
    sram_cs   = rd_acc_s | wr_acc_s;
    sram_a_d  = sram_a_q;
    sram_di_d = sram_di_q;
    sram_web  = {STRB_W{1'b1}};
    if (rd_acc_s) begin
      sram_a_d = rd_addr;
    end else if (wr_acc_s) begin
      sram_a_d  = wr_addr;
      sram_di_d = wr_data;
      sram_web  = ~wr_strb;
    end else begin
      sram_a_d = sram_a_q;
    end
  end

  // State, pin-hold and read-valid registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sram_a_q    <= {ADDR_W{1'b0}};
      sram_di_q   <= {DATA_W{1'b0}};
      rd_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sram_a_q    <= sram_a_d;
      sram_di_q   <= sram_di_d;
      rd_rvalid_q <= rd_acc_s;
    end
  end

  assign rd_gnt    = rd_gnt_s;
  assign wr_gnt    = wr_gnt_s;
  assign sram_a    = sram_a_d;
  assign sram_di   = sram_di_d;
  assign rd_rvalid = rd_rvalid_q;
  assign sram_oe   = rd_rvalid_q;
  assign rd_rdata  = rd_rvalid_q ? sram_do : {DATA_W{1'b0}};

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: behavioural SRAM on the pins, reference memory
// plus read-data scoreboard, and per-scenario tasks with inline checks.
module tb_sram_port_arbiter;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef SRAM_ARB_WRITE_PRIORITY_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rd_req = 1'b0, rd_last = 1'b0, wr_req = 1'b0, wr_last = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0, wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [STRB_W-1:0] wr_strb = '0;
  logic              rd_gnt, wr_gnt, rd_rvalid, sram_cs, sram_oe;
  logic [DATA_W-1:0] rd_rdata, sram_di;
  logic [DATA_W-1:0] sram_do = '0;
  logic [ADDR_W-1:0] sram_a;
  logic [STRB_W-1:0] sram_web;

  logic [DATA_W-1:0] sram_mem [0:DEPTH-1];
  logic [DATA_W-1:0] ref_mem  [0:DEPTH-1];
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] exp_word;
  logic              exp_valid;
  int checks = 0;
  int errors = 0;

  sram_port_arbiter dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_last(rd_last), .rd_gnt(rd_gnt),
    .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_last(wr_last), .wr_gnt(wr_gnt),
    .sram_a(sram_a), .sram_di(sram_di), .sram_web(sram_web), .sram_cs(sram_cs),
    .sram_oe(sram_oe), .sram_do(sram_do)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Behavioural SRAM driven only by the DUT pins.
  always @(posedge clk) begin
    if (sram_cs) begin
      if (&sram_web) sram_do <= sram_mem[sram_a];
      for (int b = 0; b < STRB_W; b++)
        if (!sram_web[b]) sram_mem[sram_a][b*8 +: 8] <= sram_di[b*8 +: 8];
    end
  end

  // Scoreboard: read data expected one cycle after each accepted read beat.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      exp_valid = (exp_q.size() > 0);
      exp_word  = exp_valid ? exp_q.pop_front() : '0;
      checks++;
      if (rd_rvalid !== exp_valid || sram_oe !== exp_valid || rd_rdata !== exp_word) begin
        errors++;
        $display("FAIL sb_rdata t=%0t got rvalid=%b oe=%b rdata=%h want rvalid=%b oe=%b rdata=%h",
                 $time, rd_rvalid, sram_oe, rd_rdata, exp_valid, exp_valid, exp_word);
      end
      if (rd_gnt && rd_req) exp_q.push_back(ref_mem[rd_addr]);
      if (wr_gnt && wr_req)
        for (int b = 0; b < STRB_W; b++)
          if (wr_strb[b]) ref_mem[wr_addr][b*8 +: 8] = wr_data[b*8 +: 8];
    end
  end

  task automatic next_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd_req = 1'b0; rd_last = 1'b0; wr_req = 1'b0; wr_last = 1'b0; wr_strb = '0;
  endtask

  task automatic set_rd(input logic [ADDR_W-1:0] a, input logic last);
    rd_req = 1'b1; rd_addr = a; rd_last = last;
  endtask

  task automatic set_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic [STRB_W-1:0] s, input logic last);
    wr_req = 1'b1; wr_addr = a; wr_data = d; wr_strb = s; wr_last = last;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({rd_gnt, wr_gnt, rd_rvalid, sram_cs, sram_oe} !== 5'b00000 || rd_rdata !== 32'h0 ||
        sram_web !== 4'hF || sram_a !== 14'h0 || sram_di !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got gnt=%b%b rv=%b cs=%b oe=%b rdata=%h web=%h a=%h di=%h want all 0, web=f",
               rd_gnt, wr_gnt, rd_rvalid, sram_cs, sram_oe, rd_rdata, sram_web, sram_a, sram_di);
    end
    next_drive();
    rst = 1'b0;
  endtask

  task automatic test_tie_alternation();
    logic want_rd;
    for (int i = 0; i < 3; i++) begin
      next_drive();
      set_rd(14'h0100 + 14'(i), 1'b1);
      set_wr(14'h0200 + 14'(i), 32'hD00D_0000 + 32'(i), 4'hF, 1'b1);
      want_rd = WP ? 1'b0 : (i % 2 == 0);
      @(negedge clk);
      checks++;
      if (rd_gnt !== want_rd || wr_gnt !== ~want_rd) begin
        errors++;
        $display("FAIL tie_%0d got rd_gnt=%b wr_gnt=%b want rd_gnt=%b wr_gnt=%b",
                 i, rd_gnt, wr_gnt, want_rd, ~want_rd);
      end
    end
    next_drive();
    idle_inputs();
  endtask

  task automatic test_write_burst();
    for (int i = 0; i < 4; i++) begin
      next_drive();
      set_wr(14'h0020 + 14'(i), 32'h1000_0000 + 32'(i), 4'hF, i == 3);
      set_rd(14'h0022, 1'b1);
      @(negedge clk);
      checks++;
      if (wr_gnt !== 1'b1 || rd_gnt !== 1'b0 || sram_cs !== 1'b1 || sram_a !== 14'h0020 + 14'(i) ||
          sram_di !== 32'h1000_0000 + 32'(i) || sram_web !== 4'h0) begin
        errors++;
        $display("FAIL wr_burst_beat%0d got wg=%b rg=%b cs=%b a=%h di=%h web=%h want wg=1 rg=0 cs=1 a=%h di=%h web=0",
                 i, wr_gnt, rd_gnt, sram_cs, sram_a, sram_di, sram_web, 14'h0020 + 14'(i), 32'h1000_0000 + 32'(i));
      end
    end
    next_drive();
    wr_req = 1'b0;
    @(negedge clk);
    checks++;
    if (rd_gnt !== 1'b1 || sram_a !== 14'h0022 || sram_web !== 4'hF) begin
      errors++;
      $display("FAIL rd_after_burst got rg=%b a=%h web=%h want rg=1 a=0022 web=f", rd_gnt, sram_a, sram_web);
    end
    next_drive();
    rd_req = 1'b0;
    set_wr(14'h0030, 32'hCAFE_F00D, 4'hF, 1'b1);
    @(negedge clk);
    checks++;
    if (wr_gnt !== 1'b1 || sram_cs !== 1'b1 || rd_rvalid !== 1'b1 || rd_rdata !== 32'h1000_0002) begin
      errors++;
      $display("FAIL wr_after_rd got wg=%b cs=%b rv=%b rdata=%h want wg=1 cs=1 rv=1 rdata=10000002",
               wr_gnt, sram_cs, rd_rvalid, rd_rdata);
    end
    next_drive();
    idle_inputs();
  endtask

  task automatic test_single_read();
    next_drive();
    set_rd(14'h0010, 1'b1);
    @(negedge clk);
    checks++;
    if (rd_gnt !== 1'b1 || wr_gnt !== 1'b0 || sram_cs !== 1'b1 || sram_a !== 14'h0010 || sram_web !== 4'hF) begin
      errors++;
      $display("FAIL single_rd_gnt got rg=%b wg=%b cs=%b a=%h web=%h want rg=1 wg=0 cs=1 a=0010 web=f",
               rd_gnt, wr_gnt, sram_cs, sram_a, sram_web);
    end
    next_drive();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (rd_rvalid !== 1'b1 || sram_oe !== 1'b1 || rd_rdata !== init_word(16'h0010) || sram_cs !== 1'b0) begin
      errors++;
      $display("FAIL single_rd_data got rv=%b oe=%b rdata=%h cs=%b want rv=1 oe=1 rdata=%h cs=0",
               rd_rvalid, sram_oe, rd_rdata, sram_cs, init_word(16'h0010));
    end
  endtask

  task automatic test_strobe();
    next_drive();
    set_wr(14'h0040, 32'hAABB_CCDD, 4'b0101, 1'b1);
    @(negedge clk);
    checks++;
    if (wr_gnt !== 1'b1 || sram_cs !== 1'b1 || sram_web !== 4'b1010) begin
      errors++;
      $display("FAIL strb_0101 got wg=%b cs=%b web=%b want wg=1 cs=1 web=1010", wr_gnt, sram_cs, sram_web);
    end
    next_drive();
    set_wr(14'h0040, 32'h0000_0000, 4'b0000, 1'b1);
    @(negedge clk);
    checks++;
    if (wr_gnt !== 1'b1 || sram_cs !== 1'b1 || sram_web !== 4'b1111) begin
      errors++;
      $display("FAIL strb_zero got wg=%b cs=%b web=%b want wg=1 cs=1 web=1111", wr_gnt, sram_cs, sram_web);
    end
    next_drive();
    idle_inputs();
    set_rd(14'h0040, 1'b1);
    next_drive();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (rd_rvalid !== 1'b1 || rd_rdata !== 32'hFFBB_FFDD) begin
      errors++;
      $display("FAIL strb_readback got rv=%b rdata=%h want rv=1 rdata=ffbbffdd", rd_rvalid, rd_rdata);
    end
  endtask

  task automatic test_lock_hold();
    next_drive();
    set_rd(14'h0060, 1'b0);
    next_drive();
    rd_req = 1'b0;
    set_wr(14'h0031, 32'h1234_5678, 4'hF, 1'b1);
    @(negedge clk);
    checks++;
    if (rd_gnt !== 1'b0 || wr_gnt !== 1'b0 || sram_cs !== 1'b0 || sram_a !== 14'h0060 || sram_web !== 4'hF) begin
      errors++;
      $display("FAIL lock_gap got rg=%b wg=%b cs=%b a=%h web=%h want rg=0 wg=0 cs=0 a=0060 web=f",
               rd_gnt, wr_gnt, sram_cs, sram_a, sram_web);
    end
    next_drive();
    set_rd(14'h0061, 1'b1);
    @(negedge clk);
    checks++;
    if (rd_gnt !== 1'b1 || wr_gnt !== 1'b0) begin
      errors++;
      $display("FAIL lock_last got rg=%b wg=%b want rg=1 wg=0", rd_gnt, wr_gnt);
    end
    next_drive();
    rd_req = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_gnt !== 1'b1 || sram_a !== 14'h0031) begin
      errors++;
      $display("FAIL lock_release got wg=%b a=%h want wg=1 a=0031", wr_gnt, sram_a);
    end
    next_drive();
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [4:0] rv_seen;
    rv_seen = '0;
    for (int i = 0; i < 5; i++) begin
      next_drive();
      if (i < 3) set_rd(14'h0010 + 14'(i), i == 2);
      else idle_inputs();
      @(negedge clk);
      rv_seen[i] = rd_rvalid;
    end
    checks++;
    if (rv_seen !== 5'b01110) begin
      errors++;
      $display("FAIL b2b_rvalid got %b want 01110 (cycle0 at lsb)", rv_seen);
    end
  endtask

  task automatic test_reset_mid_burst();
    next_drive();
    set_rd(14'h0050, 1'b0);
    next_drive();
    set_rd(14'h0051, 1'b0);
    set_wr(14'h0070, 32'h5555_AAAA, 4'hF, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (rd_gnt !== 1'b0 || wr_gnt !== 1'b0 || sram_cs !== 1'b0 || rd_rvalid !== 1'b0 ||
        sram_oe !== 1'b0 || sram_a !== 14'h0) begin
      errors++;
      $display("FAIL rst_mid_burst got rg=%b wg=%b cs=%b rv=%b oe=%b a=%h want all 0",
               rd_gnt, wr_gnt, sram_cs, rd_rvalid, sram_oe, sram_a);
    end
    next_drive();
    rst = 1'b0;
    set_rd(14'h0072, 1'b1);
    @(negedge clk);
    checks++;
    if (rd_gnt !== ~WP || wr_gnt !== WP) begin
      errors++;
      $display("FAIL rst_then_tie got rg=%b wg=%b want rg=%b wg=%b", rd_gnt, wr_gnt, ~WP, WP);
    end
    next_drive();
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      sram_mem[i] = init_word(i);
      ref_mem[i]  = init_word(i);
    end
    sram_mem[16'h0040] = 32'hFFFF_FFFF;
    ref_mem[16'h0040]  = 32'hFFFF_FFFF;
    test_reset();
    test_tie_alternation();
    test_write_burst();
    test_single_read();
    test_strobe();
    test_lock_hold();
    test_back_to_back();
    test_reset_mid_burst();
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
